// File: rtl/seg_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scan controller with a per-digit register file.
// Each slot starts with an anode-off window so the previous digit cannot ghost into the next.
module seg_scan_ctrl #(
  parameter int CLK_DIV   = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic [7:0] digit_en,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       E,
  output logic       F,
  output logic       G,
  output logic       anode0,
  output logic       anode1,
  output logic       anode2,
  output logic       anode3,
  output logic       anode4,
  output logic       anode5,
  output logic       anode6,
  output logic       anode7,
  output logic [2:0] cur_digit
);

  localparam int                CNT_W     = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  BLANK_END = CNT_W'(BLANK_CYC);

  logic [3:0]       dreg [8];
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic             drive;
  logic             sel;
  logic [7:0]       an_next;
  logic [6:0]       seg_next;
  logic [7:0]       an_q;
  logic [6:0]       seg_q;
  logic [2:0]       cur_q;

  // Lit-segment pattern {A..G} for each hex code, 1 = segment on.
  function automatic logic [6:0] font(input logic [3:0] v);
    logic [6:0] f;
    case (v)
      4'h0:    f = 7'b1111110;
      4'h1:    f = 7'b0110000;
      4'h2:    f = 7'b1101101;
      4'h3:    f = 7'b1111001;
      4'h4:    f = 7'b0110011;
      4'h5:    f = 7'b1011011;
      4'h6:    f = 7'b1011111;
      4'h7:    f = 7'b1110000;
      4'h8:    f = 7'b1111111;
      4'h9:    f = 7'b1111011;
      4'hA:    f = 7'b1110111;
      4'hB:    f = 7'b0011111;
      4'hC:    f = 7'b1001110;
      4'hD:    f = 7'b0111101;
      4'hE:    f = 7'b1001111;
      default: f = 7'b1000111;
    endcase
    return f;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) dreg[i] <= 4'h0;
    end else if (wr_en) begin
      dreg[wr_addr] <= wr_data;
    end
  end

  // Prescaler and slot index; idx wraps 7 -> 0 naturally in 3 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= 3'd0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= idx + 3'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Phase is derived from cnt, so the blank window needs no state of its own.
  always_comb begin
    drive    = (cnt >= BLANK_END);
    sel      = drive && digit_en[idx];
    an_next  = 8'hFF;
    seg_next = 7'h7F;
    if (sel) begin
      an_next[idx] = 1'b0;
      seg_next     = ~font(dreg[idx]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q  <= 8'hFF;
      seg_q <= 7'h7F;
      cur_q <= 3'd0;
    end else begin
      an_q  <= an_next;
      seg_q <= seg_next;
      cur_q <= idx;
    end
  end

  assign {A, B, C, D, E, F, G} = seg_q;
  assign {anode7, anode6, anode5, anode4, anode3, anode2, anode1, anode0} = an_q;
  assign cur_digit = cur_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: two instances (8/2 and 4/2 prescaling) against a time-based reference model.
module tb_seg_scan_ctrl;

  localparam int DIV_A = 8;
  localparam int BLK_A = 2;
  localparam int DIV_B = 4;
  localparam int BLK_B = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = 3'd0;
  logic [3:0] wr_data = 4'd0;
  logic [7:0] digit_en = 8'hFF;

  logic [6:0] seg_a, seg_b;
  logic [7:0] an_a, an_b;
  logic [2:0] cur_a, cur_b;

  int errors = 0;
  int checks = 0;

  logic [6:0] font_lit [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                                7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
  logic [3:0] mdreg [8];
  int         edges;
  int         last_low [2];
  int         high_run [2];
  logic [2:0] prev_cur_b;
  int         last_wrap;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.CLK_DIV(DIV_A), .BLANK_CYC(BLK_A)) u_dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .digit_en(digit_en),
    .A(seg_a[6]), .B(seg_a[5]), .C(seg_a[4]), .D(seg_a[3]), .E(seg_a[2]), .F(seg_a[1]), .G(seg_a[0]),
    .anode0(an_a[0]), .anode1(an_a[1]), .anode2(an_a[2]), .anode3(an_a[3]),
    .anode4(an_a[4]), .anode5(an_a[5]), .anode6(an_a[6]), .anode7(an_a[7]),
    .cur_digit(cur_a)
  );

  seg_scan_ctrl #(.CLK_DIV(DIV_B), .BLANK_CYC(BLK_B)) u_dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .digit_en(digit_en),
    .A(seg_b[6]), .B(seg_b[5]), .C(seg_b[4]), .D(seg_b[3]), .E(seg_b[2]), .F(seg_b[1]), .G(seg_b[0]),
    .anode0(an_b[0]), .anode1(an_b[1]), .anode2(an_b[2]), .anode3(an_b[3]),
    .anode4(an_b[4]), .anode5(an_b[5]), .anode6(an_b[6]), .anode7(an_b[7]),
    .cur_digit(cur_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h (edge %0d)", tag, got, exp, edges);
    end
  endtask

  // Outputs after edge e+1 reflect cycle e since release: slot e/div, position e%div.
  task automatic expectFor(input int div, input int blk, input int e,
                           output logic [7:0] an, output logic [6:0] seg, output logic [2:0] cur);
    int pos;
    int slot;
    pos  = e % div;
    slot = (e / div) % 8;
    an   = 8'hFF;
    seg  = 7'h7F;
    cur  = 3'(slot);
    if (pos >= blk && digit_en[slot]) begin
      an[slot] = 1'b0;
      seg      = ~font_lit[mdreg[slot]];
    end
  endtask

  task automatic gapTrack(input int k, input logic [7:0] an, input int blk);
    int low;
    low = -1;
    for (int i = 0; i < 8; i++) if (!an[i]) low = i;
    checkOutput((k == 0) ? "onehot_a" : "onehot_b", 32'($countones(~an) <= 1), 32'd1);
    if (low >= 0) begin
      if (last_low[k] >= 0 && low != last_low[k])
        checkOutput((k == 0) ? "gap_a" : "gap_b", 32'(high_run[k] >= blk), 32'd1);
      last_low[k] = low;
      high_run[k] = 0;
    end else begin
      high_run[k]++;
    end
  endtask

  task automatic stepCycle();
    logic [7:0] ea, eb;
    logic [6:0] sa, sb;
    logic [2:0] ca, cb;
    expectFor(DIV_A, BLK_A, edges, ea, sa, ca);
    expectFor(DIV_B, BLK_B, edges, eb, sb, cb);
    @(posedge clk);
    if (wr_en) mdreg[wr_addr] = wr_data;
    edges++;
    #1;
    checkOutput("anode_a", 32'(an_a), 32'(ea));
    checkOutput("seg_a", 32'(seg_a), 32'(sa));
    checkOutput("cur_a", 32'(cur_a), 32'(ca));
    checkOutput("anode_b", 32'(an_b), 32'(eb));
    checkOutput("seg_b", 32'(seg_b), 32'(sb));
    checkOutput("cur_b", 32'(cur_b), 32'(cb));
    gapTrack(0, an_a, BLK_A);
    gapTrack(1, an_b, BLK_B);
    if (prev_cur_b == 3'd7 && cur_b == 3'd0) begin
      if (last_wrap >= 0) checkOutput("wrap_b", 32'(edges - last_wrap), 32'(8 * DIV_B));
      last_wrap = edges;
    end
    prev_cur_b = cur_b;
  endtask

  task automatic applyStimulus(input logic en, input logic [2:0] a, input logic [3:0] d,
                               input logic [7:0] den);
    wr_en    = en;
    wr_addr  = a;
    wr_data  = d;
    digit_en = den;
    stepCycle();
  endtask

  // Asynchronous reset: outputs must go idle before any clock edge arrives.
  task automatic doReset();
    wr_en = 1'b0;
    rst   = 1'b1;
    #1;
    checkOutput("rst_anode_a", 32'(an_a), 32'hFF);
    checkOutput("rst_seg_a", 32'(seg_a), 32'h7F);
    checkOutput("rst_cur_a", 32'(cur_a), 32'd0);
    checkOutput("rst_anode_b", 32'(an_b), 32'hFF);
    checkOutput("rst_seg_b", 32'(seg_b), 32'h7F);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_hold_a", 32'(an_a), 32'hFF);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) mdreg[i] = 4'h0;
    edges       = 0;
    last_low[0] = -1;
    last_low[1] = -1;
    high_run[0] = 0;
    high_run[1] = 0;
    prev_cur_b  = 3'd0;
    last_wrap   = -1;
  endtask

  initial begin
    int cnt_low;
    bit found;
    #2;
    doReset();

    // Mid-slot reset, then first-drive latency on digit 0
    repeat (5) applyStimulus(1'b0, 3'd0, 4'd0, 8'hFF);
    doReset();
    applyStimulus(1'b0, 3'd0, 4'd0, 8'hFF);
    checkOutput("first_blank1", 32'(an_a), 32'hFF);
    applyStimulus(1'b0, 3'd0, 4'd0, 8'hFF);
    checkOutput("first_blank2", 32'(an_a), 32'hFF);
    applyStimulus(1'b0, 3'd0, 4'd0, 8'hFF);
    checkOutput("first_drive_an", 32'(an_a), 32'hFE);
    checkOutput("first_drive_seg", 32'(seg_a), 32'b0000001);

    // Full scan with digits 1..8, then a write to the live digit 3
    doReset();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 3'(i), 4'(i + 1), 8'hFF);
    wr_en = 1'b0;
    while (edges < 27) stepCycle();
    checkOutput("live_before_an", 32'(an_a), 32'hF7);
    checkOutput("live_before_seg", 32'(seg_a), 32'b1001100);
    applyStimulus(1'b1, 3'd3, 4'd9, 8'hFF);
    checkOutput("live_same_edge", 32'(seg_a), 32'b1001100);
    applyStimulus(1'b0, 3'd0, 4'd0, 8'hFF);
    checkOutput("live_next_edge", 32'(seg_a), 32'b0000100);
    checkOutput("live_an", 32'(an_a), 32'hF7);
    repeat (16 * DIV_A) stepCycle();

    // Every hex code on digit 0
    for (int c = 0; c < 16; c++) begin
      applyStimulus(1'b1, 3'd0, 4'(c), 8'hFF);
      wr_en = 1'b0;
      found = 1'b0;
      for (int n = 0; n < 10 * DIV_A && !found; n++) begin
        stepCycle();
        if (an_a == 8'hFE) found = 1'b1;
      end
      checkOutput("font_wait", 32'(found), 32'd1);
      if (c == 10) checkOutput("font_A", 32'(seg_a), 32'b0001000);
      if (c == 15) checkOutput("font_F", 32'(seg_a), 32'b0111000);
    end

    // Blanking mask: digits 1 and 3 disabled
    cnt_low = 0;
    digit_en = 8'b1111_0101;
    repeat (16 * DIV_A) begin
      stepCycle();
      if (!an_a[1] || !an_a[3]) cnt_low++;
    end
    checkOutput("mask_low_count", 32'(cnt_low), 32'd0);

    // Randomized writes and enables, with one reset dropped in mid-run
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) doReset();
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 9) == 0) ? 8'($urandom) : digit_en);
    end

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
